// File: rtl/pipe_stage_reg_if.sv
// Inter-stage pipeline register bundle: upstream slot, pipeline controls and the registered slot.
// Master drives the upstream slot and controls; slave is the register stage itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic              flush;
    logic              stall;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        stall_cnt;
    logic [15:0]       bubble_count;

    modport master (
        output in_valid, in_ctrl, in_data, hold, flush, stall,
        input  out_valid, out_ctrl, out_data, stall_cnt, bubble_count
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, hold, flush, stall,
        output out_valid, out_ctrl, out_data, stall_cnt, bubble_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with hold, flush and stall-run bubble injection.
// Optional bubble counter enabled by defining PIPE_BUBBLE_CNT_EN (otherwise bubble_count reads 0).
module pipe_stage_reg #(
    parameter int                DATA_W           = 32,
    parameter int                CTRL_W           = 16,
    parameter logic [CTRL_W-1:0] NOP_CTRL         = {CTRL_W{1'b0}},
    parameter int                CLR_STALL_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    pipe_stage_reg_if.slave bus
);

    if ((CLR_STALL_CYCLES < 1) || (CLR_STALL_CYCLES > 15)) begin : g_bad_clr_stall
        $error("pipe_stage_reg: CLR_STALL_CYCLES must be within 1..15");
    end

    localparam logic [3:0] CLR_CNT = 4'(CLR_STALL_CYCLES);

    // Length of the current stall run after one more stalled edge, pinned at the threshold.
    function automatic logic [3:0] stall_run_next(input logic [3:0] cnt);
        logic [3:0] nxt;
        if (cnt >= CLR_CNT) begin
            nxt = CLR_CNT;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;
    logic [3:0]        stall_cnt_r;

    logic              valid_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic [DATA_W-1:0] data_s;
    logic [3:0]        stall_cnt_s;
    logic [3:0]        stall_inc_s;

    // Next-slot selection in priority order flush > hold > stall > normal load.
    always_comb begin
        valid_s     = valid_r;
        ctrl_s      = ctrl_r;
        data_s      = data_r;
        stall_cnt_s = stall_cnt_r;
        stall_inc_s = stall_run_next(stall_cnt_r);
        if (bus.flush) begin
            valid_s     = 1'b0;
            ctrl_s      = NOP_CTRL;
            stall_cnt_s = 4'd0;
        end else if (bus.hold) begin
            valid_s     = valid_r;
            ctrl_s      = ctrl_r;
            data_s      = data_r;
            stall_cnt_s = stall_cnt_r;
        end else if (bus.stall) begin
            stall_cnt_s = stall_inc_s;
            if (stall_inc_s == CLR_CNT) begin
                // Payload is kept so a squashed slot still shows the last operands.
                valid_s = 1'b0;
                ctrl_s  = NOP_CTRL;
            end else begin
                valid_s = bus.in_valid;
                ctrl_s  = bus.in_ctrl;
                data_s  = bus.in_data;
            end
        end else begin
            valid_s     = bus.in_valid;
            ctrl_s      = bus.in_ctrl;
            data_s      = bus.in_data;
            stall_cnt_s = 4'd0;
        end
    end

    // Slot and stall-run state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r     <= 1'b0;
            ctrl_r      <= NOP_CTRL;
            data_r      <= {DATA_W{1'b0}};
            stall_cnt_r <= 4'd0;
        end else begin
            valid_r     <= valid_s;
            ctrl_r      <= ctrl_s;
            data_r      <= data_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign bus.out_valid = valid_r;
    assign bus.out_ctrl  = ctrl_r;
    assign bus.out_data  = data_r;
    assign bus.stall_cnt = stall_cnt_r;

`ifdef PIPE_BUBBLE_CNT_EN
    logic        bubble_s;
    logic [15:0] bubble_cnt_r;

    // An injected bubble is a flush, or an unheld stall that reaches the threshold.
    assign bubble_s = bus.flush |
                      (~bus.hold & bus.stall & (stall_run_next(stall_cnt_r) == CLR_CNT));

    // Saturating bubble counter; never wraps so long runs stay visibly pegged.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r <= 16'h0000;
        end else if (bubble_s && (bubble_cnt_r != 16'hFFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'h0001;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bus.bubble_count = bubble_cnt_r;
`else
    assign bus.bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic against a
// run-length reference model; counter expectations follow PIPE_BUBBLE_CNT_EN.
module tb_pipe_stage_reg;
    localparam int          DATA_W = 32;
    localparam int          CTRL_W = 16;
    localparam logic [15:0] NOP    = 16'h0013;
    localparam int          CLR    = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP), .CLR_STALL_CYCLES(CLR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: slot contents, length of the unheld stall run, bubbles injected.
    logic        m_valid;
    logic [15:0] m_ctrl;
    logic [31:0] m_data;
    int          m_run;
    int          m_bub;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic f, input logic h,
                        input logic s, input logic v, input logic [15:0] c,
                        input logic [31:0] d);
        logic [3:0]  exp_stall;
        logic [15:0] exp_bub;
        rst          = r;
        bus.flush    = f;
        bus.hold     = h;
        bus.stall    = s;
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_data  = d;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_ctrl = NOP; m_data = 32'h0; m_run = 0; m_bub = 0;
        end else if (f) begin
            m_valid = 1'b0; m_ctrl = NOP; m_run = 0; m_bub++;
        end else if (h) begin
            m_run = m_run;
        end else if (s) begin
            m_run++;
            if (m_run >= CLR) begin
                m_valid = 1'b0; m_ctrl = NOP; m_bub++;
            end else begin
                m_valid = v; m_ctrl = c; m_data = d;
            end
        end else begin
            m_valid = v; m_ctrl = c; m_data = d; m_run = 0;
        end
        exp_stall = 4'((m_run < CLR) ? m_run : CLR);
`ifdef PIPE_BUBBLE_CNT_EN
        exp_bub = 16'((m_bub < 65535) ? m_bub : 65535);
`else
        exp_bub = 16'h0000;
`endif
        #1;
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, ".ctrl"}, 32'(bus.out_ctrl), 32'(m_ctrl));
        check({tag, ".data"}, bus.out_data, m_data);
        check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_stall));
        check({tag, ".bubbles"}, 32'(bus.bubble_count), 32'(exp_bub));
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.hold = 1'b0; bus.stall = 1'b0;
        bus.in_valid = 1'b0; bus.in_ctrl = 16'h0; bus.in_data = 32'h0;
        m_valid = 1'b0; m_ctrl = NOP; m_data = 32'h0; m_run = 0; m_bub = 0;

        // T1: reset then first load
        step("t1_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A5, 32'h1234_5678);
        step("t1_rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A5, 32'h1234_5678);
        check("t1_rst_valid", 32'(bus.out_valid), 32'h0);
        check("t1_rst_ctrl", 32'(bus.out_ctrl), 32'h0013);
        step("t1_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A5, 32'h1234_5678);
        check("t1_load_valid", 32'(bus.out_valid), 32'h1);
        check("t1_load_ctrl", 32'(bus.out_ctrl), 32'h0000_00A5);
        check("t1_load_data", bus.out_data, 32'h1234_5678);

        // T2: three stalled edges, threshold 2
        step("t2_e1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 32'hDEAD_BEEF);
        check("t2_e1_cnt", 32'(bus.stall_cnt), 32'h1);
        check("t2_e1_data", bus.out_data, 32'hDEAD_BEEF);
        step("t2_e2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 32'hDEAD_BEEF);
        check("t2_e2_valid", 32'(bus.out_valid), 32'h0);
        step("t2_e3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 32'hDEAD_BEEF);
        check("t2_e3_cnt", 32'(bus.stall_cnt), 32'h2);
`ifdef PIPE_BUBBLE_CNT_EN
        check("t2_bubbles", 32'(bus.bubble_count), 32'h2);
`endif

        // T3: flush beats stall
        step("t3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0777, 32'h0BAD_F00D);
        check("t3_cnt", 32'(bus.stall_cnt), 32'h0);

        // T4: one stall edge, then hold+stall with changing inputs, then release
        step("t4_pre", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 32'hCAFE_0001);
        for (int i = 0; i < 4; i++) begin
            step("t4_hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'(i), 16'(16'h2000 + i), $urandom);
            check("t4_hold_cnt", 32'(bus.stall_cnt), 32'h1);
            check("t4_hold_data", bus.out_data, 32'hCAFE_0001);
        end
        step("t4_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3333, 32'hCAFE_0002);
        check("t4_rel_data", bus.out_data, 32'hCAFE_0002);

        // T5: stall 1,0,1 never bubbles
        step("t5_a", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0501, 32'h5000_0001);
        step("t5_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0502, 32'h5000_0002);
        step("t5_c", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0503, 32'h5000_0003);
        check("t5_c_valid", 32'(bus.out_valid), 32'h1);
        check("t5_c_cnt", 32'(bus.stall_cnt), 32'h1);

        // Reset in the middle of a stall run leaves no residual count
        step("rs_stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0601, 32'h6000_0001);
        step("rs_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0602, 32'h6000_0002);
        step("rs_after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0603, 32'h6000_0003);
        check("rs_after_cnt", 32'(bus.stall_cnt), 32'h1);

        // T6: bubble counter saturation (or stays zero when the counter is compiled out)
        step("t6_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
`ifdef PIPE_BUBBLE_CNT_EN
        for (int i = 0; i < 65534; i++) begin
            step("t6_pre", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0);
        end
        check("t6_pre_cnt", 32'(bus.bubble_count), 32'h0000_FFFE);
`endif
        for (int i = 0; i < 3; i++) begin
            step("t6_flush", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0);
        end
`ifdef PIPE_BUBBLE_CNT_EN
        check("t6_sat", 32'(bus.bubble_count), 32'h0000_FFFF);
`else
        check("t6_off", 32'(bus.bubble_count), 32'h0);
`endif

        // Random traffic against the model
        step("rnd_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 1'(($urandom % 40) == 0), 1'(($urandom % 10) == 0),
                 1'(($urandom % 6) == 0), 1'($urandom % 2), 1'($urandom % 2),
                 16'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
